hamming_serial_feeder: RTL and testbench

//  Upstream sequencer for the bit-serial Hamming-distance accumulator.
//  - Accepts one N-bit garbler word and one N-bit evaluator word per job over a valid/ready handshake.
//  - Serialises the two words LSB-first, one bit pair per clock, into the accumulator.
//  - Clears the accumulator at job start; captures its CNT_W-bit count after bit N-1.
//  - Returns the count over a valid/ready handshake.

---
 rtl/hamming_pkg.sv | 20 ++
 rtl/hamming_piso.sv | 34 +++
 rtl/hamming_serial_feeder.sv | 124 ++++++++++++
 tb/tb_hamming_serial_feeder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types and sizing helpers for the Hamming-distance datapath
// (feeder, accumulator and downstream comparator).
package hamming_pkg;

  localparam int unsigned HAM_N     = 32;
  localparam int unsigned HAM_CNT_W = 6;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StShift,
    StCapt,
    StDone
  } feeder_state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hamming_piso.sv
// N-bit parallel-in serial-out register: parallel load, right shift with zero fill.
module hamming_piso #(
  parameter int unsigned N = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [N-1:0] din_i,
  output logic         dout_lsb_o
);

  logic [N-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load_i) begin
      sh_d = din_i;
    end else if (shift_i) begin
      sh_d = {1'b0, sh_q[N-1:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign dout_lsb_o = sh_q[0];

endmodule

// File: rtl/hamming_serial_feeder.sv
// Sequencer that streams two N-bit words LSB-first into the bit-serial Hamming
// accumulator and returns the captured count over a valid/ready handshake.
module hamming_serial_feeder
  import hamming_pkg::*;
#(
  parameter int unsigned N     = HAM_N,
  parameter int unsigned CNT_W = HAM_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N-1:0]     g_word_i,
  input  logic [N-1:0]     e_word_i,
  output logic             g_bit_o,
  output logic             e_bit_o,
  output logic             bit_valid_o,
  output logic             acc_clr_o,
  input  logic [CNT_W-1:0] acc_count_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] out_count_o,
  output logic             busy_o
);

  localparam int unsigned    IdxW    = $clog2(N);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);

  // The count reaches N, so the width must hold N without wrapping.
  if (CNT_W < cnt_width(N)) begin : g_cnt_w_check
    $error("CNT_W is too narrow to hold a count of N");
  end

  feeder_state_t    state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, shift;
  logic             g_lsb, e_lsb;

  hamming_piso #(.N(N)) u_g_piso (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (load),
    .shift_i    (shift),
    .din_i      (g_word_i),
    .dout_lsb_o (g_lsb)
  );

  hamming_piso #(.N(N)) u_e_piso (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (load),
    .shift_i    (shift),
    .din_i      (e_word_i),
    .dout_lsb_o (e_lsb)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    load        = 1'b0;
    shift       = 1'b0;
    in_ready_o  = 1'b0;
    bit_valid_o = 1'b0;
    acc_clr_o   = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = StClr;
        end
      end
      StClr: begin
        acc_clr_o = 1'b1;
        state_d   = StShift;
      end
      StShift: begin
        bit_valid_o = 1'b1;
        shift       = 1'b1;
        if (idx_q == IdxLast) begin
          idx_d   = '0;
          state_d = StCapt;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StCapt: begin
        // Accumulator output already includes bit N-1 here.
        cnt_d   = acc_count_i;
        state_d = StDone;
      end
      StDone: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gated so the free-running accumulator adds zero outside SHIFT.
  assign g_bit_o     = bit_valid_o & g_lsb;
  assign e_bit_o     = bit_valid_o & e_lsb;
  assign out_count_o = cnt_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_hamming_serial_feeder.sv
// Self-checking bench: feeder plus accumulator model, random and directed jobs
// compared each cycle against a job-timeline reference model.
module tb_hamming_serial_feeder;

  localparam int N     = 32;
  localparam int CNT_W = 6;
  localparam int LAT   = N + 3;

  logic             clk_i = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [N-1:0]     g_word, e_word;
  logic             g_bit, e_bit, bit_valid, acc_clr;
  logic [CNT_W-1:0] acc_count;
  logic             out_valid, out_ready;
  logic [CNT_W-1:0] out_count;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  hamming_serial_feeder #(.N(N), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .g_word_i    (g_word),
    .e_word_i    (e_word),
    .g_bit_o     (g_bit),
    .e_bit_o     (e_bit),
    .bit_valid_o (bit_valid),
    .acc_clr_o   (acc_clr),
    .acc_count_i (acc_count),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_count_o (out_count),
    .busy_o      (busy)
  );

  // Free-running serial Hamming accumulator.
  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)       acc_count <= '0;
    else if (acc_clr) acc_count <= '0;
    else              acc_count <= acc_count + CNT_W'(g_bit ^ e_bit);
  end

  // Reference: m_t is the cycle index within a job (1 = first cycle after accept).
  bit               m_active;
  int               m_t;
  logic [N-1:0]     m_g, m_e;
  logic [CNT_W-1:0] m_cnt;

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_cnt    <= '0;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active <= 1'b1;
        m_t      <= 1;
        m_g      <= g_word;
        m_e      <= e_word;
      end
    end else if (m_t == LAT) begin
      if (out_ready) m_active <= 1'b0;
    end else begin
      m_t <= m_t + 1;
      if (m_t == LAT - 1) m_cnt <= CNT_W'($countones(m_g ^ m_e));
    end
  end

  task automatic chk(input bit ok, input string name, input longint got, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    logic [6:0] got;
    got = {in_ready, busy, acc_clr, bit_valid, g_bit, e_bit, out_valid};
    chk(got === 7'b1000000, {name, "_ctrl"}, longint'(got), 64);
    chk(out_count === '0, {name, "_count"}, longint'(out_count), 0);
  endtask

  // Drive a job, wait for the result, hold out_ready low for `hold` cycles, then take it.
  task automatic run_job(input logic [N-1:0] g, input logic [N-1:0] e, input int hold,
                         input logic [CNT_W-1:0] exp_cnt, input string name);
    int lat, bv, clr;
    bit ok, stable;
    @(negedge clk_i);
    g_word = g; e_word = e; in_valid = 1'b1; out_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk_i);
    end
    chk(ok, {name, "_accept"}, longint'(ok), 1);
    @(negedge clk_i);
    in_valid = 1'b0;
    lat = 1; bv = 0; clr = 0;
    while (!out_valid && lat < 100) begin
      bv  += int'(bit_valid);
      clr += int'(acc_clr);
      @(negedge clk_i);
      lat++;
    end
    chk(lat == LAT, {name, "_latency"}, lat, LAT);
    chk(out_count === exp_cnt, {name, "_count"}, longint'(out_count), longint'(exp_cnt));
    chk(bv == N, {name, "_bit_valid_cycles"}, bv, N);
    chk(clr == 1, {name, "_acc_clr_cycles"}, clr, 1);
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk_i);
        if (!(out_valid && !in_ready && out_count === exp_cnt)) stable = 1'b0;
      end
      chk(stable, {name, "_hold_stable"}, longint'(out_count), longint'(exp_cnt));
    end
    out_ready = 1'b1;
    @(negedge clk_i);
    out_ready = 1'b0;
    chk(in_ready === 1'b1, {name, "_idle_after"}, longint'(in_ready), 1);
  endtask

  initial begin
    int acc_idx[$];
    int lat;
    logic [7:0] exp_v, got_v;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; g_word = '0; e_word = '0;

    fork
      forever begin
        @(negedge clk_i);
        if (rst_n) begin
          bit bv_e;
          int b;
          bv_e  = m_active && m_t >= 2 && m_t <= N + 1;
          b     = bv_e ? m_t - 2 : 0;
          exp_v = {!m_active, m_active, m_active && m_t == 1, bv_e,
                   bv_e & m_g[b], bv_e & m_e[b], m_active && m_t == LAT, 1'b0};
          got_v = {in_ready, busy, acc_clr, bit_valid, g_bit, e_bit, out_valid, 1'b0};
          checks++;
          if (got_v !== exp_v || out_count !== m_cnt) begin
            errors++;
            $display("FAIL model_cmp at %0t: got ctrl=%b cnt=%0d expected ctrl=%b cnt=%0d",
                     $time, got_v, out_count, exp_v, m_cnt);
          end
        end
      end
    join_none

    #12;
    chk_reset_outputs("reset_in");
    @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
    chk_reset_outputs("reset_out");

    run_job(32'h0000_0000, 32'h0000_0000, 0, 6'd0,  "zero");
    run_job(32'hFFFF_FFFF, 32'h0000_0000, 0, 6'd32, "all_ones");
    run_job(32'hA5A5_0F0F, 32'h5A5A_0F0E, 2, 6'd17, "mixed");
    run_job(32'hFFFF_0000, 32'h0000_00FF, 10, 6'd24, "b2b_first");
    run_job(32'h0000_0001, 32'h0000_0003, 0, 6'd1,  "b2b_second");

    // Reset in the middle of SHIFT at idx 12.
    @(negedge clk_i);
    g_word = 32'hFFFF_FFFF; e_word = '0; in_valid = 1'b1;
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk_i);
    @(negedge clk_i);
    in_valid = 1'b0;
    lat = 1;
    while (lat < 14) begin @(negedge clk_i); lat++; end
    chk(bit_valid === 1'b1, "mid_shift_active", longint'(bit_valid), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_job_reset");
    @(negedge clk_i);
    rst_n = 1'b1;
    run_job(32'h0000_0001, 32'h0000_0000, 0, 6'd1, "after_reset");

    // in_valid and out_ready held high: one accept per IDLE visit, N+4 apart.
    @(negedge clk_i);
    g_word = 32'h0F0F_0F0F; e_word = 32'h0000_FFFF; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 200 && acc_idx.size() < 3; c++) begin
      if (in_ready) acc_idx.push_back(c);
      @(negedge clk_i);
    end
    chk(acc_idx.size() == 3, "stream_accepts", acc_idx.size(), 3);
    if (acc_idx.size() == 3) begin
      chk(acc_idx[1] - acc_idx[0] == N + 4, "stream_gap0", acc_idx[1] - acc_idx[0], N + 4);
      chk(acc_idx[2] - acc_idx[1] == N + 4, "stream_gap1", acc_idx[2] - acc_idx[1], N + 4);
    end

    // Random traffic checked by the reference model each cycle.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_i);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 5))
        0:       g_word = '0;
        1:       g_word = '1;
        default: g_word = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       e_word = '0;
        1:       e_word = '1;
        default: e_word = $urandom;
      endcase
    end
    @(negedge clk_i);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (N + 8) @(negedge clk_i);
    chk(in_ready === 1'b1, "drain_idle", longint'(in_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
